// File: rtl/mips_muldiv_unit.sv
// HI/LO execution unit: iterative signed MULT/DIV (one bit per cycle),
// single-cycle MTHI/MTLO, and the architectural HI/LO registers.
module mips_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hi_write,
    input  logic                  lo_write,
    input  logic [SEL_WIDTH-1:0]  hi_select,
    input  logic [SEL_WIDTH-1:0]  lo_select,
    input  logic [DATA_WIDTH-1:0] srca,
    input  logic [DATA_WIDTH-1:0] srcb,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [SEL_WIDTH-1:0] SEL_MOVE = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_DIV  = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] SEL_MUL  = SEL_WIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               op_div;
    logic               a_neg;
    logic               b_neg;
    logic [2*W-1:0]     mcand;
    logic [W-1:0]       mplier;
    logic [2*W-1:0]     acc;
    logic [W-1:0]       rem;
    logic [W-1:0]       quot;
    logic [W-1:0]       divisor;

    logic               cmd_mul;
    logic               cmd_div;
    logic               cmd_mthi;
    logic               cmd_mtlo;
    logic [W-1:0]       a_abs;
    logic [W-1:0]       b_abs;
    logic [2*W-1:0]     acc_nxt;
    logic [W:0]         rem_sh;
    logic [W:0]         diff;
    logic [2*W-1:0]     prod_fix;
    logic [W-1:0]       quot_fix;
    logic [W-1:0]       rem_fix;
    logic [W-1:0]       res_hi;
    logic [W-1:0]       res_lo;
    logic               last_iter;

    always_comb begin
        cmd_mul   = hi_write && lo_write && (hi_select == SEL_MUL) && (lo_select == SEL_MUL);
        cmd_div   = hi_write && lo_write && (hi_select == SEL_DIV) && (lo_select == SEL_DIV);
        cmd_mthi  = hi_write && (hi_select == SEL_MOVE);
        cmd_mtlo  = lo_write && (lo_select == SEL_MOVE);
        a_abs     = srca[W-1] ? -srca : srca;
        b_abs     = srcb[W-1] ? -srcb : srcb;
        last_iter = (counter == CNT_W'(W - 1));

        acc_nxt   = acc + (mplier[0] ? mcand : '0);

        // Restoring step: a negative trial (top bit set) keeps the shifted remainder.
        rem_sh    = {rem, quot[W-1]};
        diff      = rem_sh - {1'b0, divisor};

        prod_fix  = (a_neg ^ b_neg) ? -acc : acc;
        // Divide by zero: all-ones quotient; the remainder path already yields srca.
        quot_fix  = (divisor == '0) ? '1 : ((a_neg ^ b_neg) ? -quot : quot);
        rem_fix   = a_neg ? -rem : rem;
        res_hi    = op_div ? rem_fix  : prod_fix[2*W-1:W];
        res_lo    = op_div ? quot_fix : prod_fix[W-1:0];
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            counter <= '0;
            op_div  <= 1'b0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_mul || cmd_div) begin
                        state   <= cmd_mul ? S_MUL : S_DIV;
                        op_div  <= cmd_div;
                        a_neg   <= srca[W-1];
                        b_neg   <= srcb[W-1];
                        counter <= '0;
                        mcand   <= {{W{1'b0}}, a_abs};
                        mplier  <= b_abs;
                        acc     <= '0;
                        rem     <= '0;
                        quot    <= a_abs;
                        divisor <= b_abs;
                    end else begin
                        if (cmd_mthi) hi <= srca;
                        if (cmd_mtlo) lo <= srca;
                    end
                end
                S_MUL: begin
                    acc     <= acc_nxt;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + 1'b1;
                    if (last_iter) state <= S_FIX;
                end
                S_DIV: begin
                    rem     <= diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
                    quot    <= {quot[W-2:0], ~diff[W]};
                    counter <= counter + 1'b1;
                    if (last_iter) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
